seq_mac: RTL and testbench
==========================

Name: seq_mac

Overview:
- Parametrised iterative shift-add multiply-accumulate unit for the FIR datapath.
- Generalises the fixed 8x8 unsigned combinational multiplier with:
  - configurable operand widths
  - signed/unsigned mode
  - valid/ready handshakes on both sides
  - optional running accumulator for tap summation
- Sits between the sample/coefficient sequencer and the filter output stage; one product per transaction.

Parameters:
- DATA_W, 8, sample operand width (bits)
- COEF_W, 8, coefficient operand width (bits); also the number of iteration cycles
- ACC_W, 24, accumulator width; must satisfy ACC_W >= DATA_W+COEF_W

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  unit can accept operands
- sample  input  DATA_W  multiplicand
- coeff  input  COEF_W  multiplier
- signed_mode  input  1  1: operands and result are two's complement; 0: unsigned
- acc_en  input  1  add this product into the accumulator
- acc_clr  input  1  zero the accumulator before this transaction's add
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- product  output  DATA_W+COEF_W  exact product of the accepted operands
- acc_out  output  ACC_W  accumulator value

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, product=0, acc_out=0
  - iteration counter=0, internal operand registers=0
  - Reset mid-RUN or mid-DONE aborts the transaction; no output is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept edge: in_valid&&in_ready at the rising edge (T0).
  - At T0, latch sample, coeff, signed_mode, acc_en, acc_clr.
  - In signed mode, convert both operands to magnitudes and record result sign = sign(sample) XOR sign(coeff).
  - Clear the partial sum and counter; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge processes one multiplier bit, LSB first: if the bit is 1, add the shifted multiplicand to the partial sum; then shift.
  - Edges T1..T_COEF_W process the COEF_W bits.
  - At T_COEF_W:
    - apply sign correction: product = negate(partial sum) when result sign=1 in signed mode
    - register product
    - update the accumulator
    - go to DONE
- DONE:
  - out_valid=1; product and acc_out are held stable while out_valid && !out_ready.
  - Edge with out_ready=1 goes to IDLE; in_ready rises on the following cycle.
  - No same-edge accept: minimum transaction period is COEF_W+2 cycles.
- Latency: out_valid is first high in the cycle after edge T_COEF_W, i.e. COEF_W cycles after the accept edge.
- Width and arithmetic rules:
  - product is full width (DATA_W+COEF_W) and never truncates.
  - Signed extreme case: -2^(DATA_W-1) * -2^(COEF_W-1) = +2^(DATA_W+COEF_W-2), which fits.
  - Unsigned mode: zero-extend the operands.
- Accumulator:
  - next = (acc_clr ? 0 : acc) + ext(product) when acc_en=1.
  - ext is sign-extension in signed mode, zero-extension otherwise.
  - When acc_en=0 && acc_clr=1, acc becomes 0.
  - When acc_en=0 && acc_clr=0, acc is unchanged.
  - Overflow wraps modulo 2^ACC_W; no saturation, no flag.
  - acc_out persists across transactions; only reset or acc_clr clears it.
- Input changes:
  - Input changes outside the accept edge are ignored.
  - in_valid asserted during RUN/DONE is not accepted, and the request stays pending.
- Zero operand: the unit still takes the full COEF_W cycles, and product=0.

Test Plan:
- Unsigned multiply, DATA_W=COEF_W=8:
  - sample=3, coeff=5, signed_mode=0, acc_en=0 -> product=15 with out_valid high exactly 8 cycles after the accept edge.
  - Then sample=5, coeff=2 -> product=10.
- Unsigned extreme: 255*255 -> product=65025 (16'hFE01); 0*200 -> product=0 after the full 8-cycle latency.
- Signed mode:
  - sample=8'hFD (-3), coeff=5 -> product=16'hFFF1 (-15).
  - -128*-128 -> 16'h4000.
  - 127*-128 -> 16'hC080 (-16256).
- Accumulate sequence, all acc_en=1:
  - 3*5 with acc_clr=1 -> acc_out=15
  - 5*2 -> acc_out=25
  - signed -3*5 -> acc_out=10
  - acc_clr=1, acc_en=0 -> acc_out=0
- Wrap, ACC_W=16 build: 16 back-to-back unsigned 255*255 with acc_en=1 -> acc_out=(16*65025) mod 65536 = 57360.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid, product and acc_out stay stable, and in_ready stays 0.
  - Assert rst_n=0 at cycle 4 of RUN -> immediate out_valid=0, in_ready=1, acc_out=0; the next transaction 3*5 yields 15.

Source files
------------

// File: rtl/seq_mac.sv
// seq_mac: iterative shift-add multiply-accumulate, one multiplier bit per
// cycle, signed/unsigned, valid/ready on both sides, running accumulator.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       operand handshake (sample, coeff, signed_mode,
//                           acc_en, acc_clr)
//   out_valid/out_ready     result handshake (product, acc_out)
module seq_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        sample,
  input  logic [COEF_W-1:0]        coeff,
  input  logic                     signed_mode,
  input  logic                     acc_en,
  input  logic                     acc_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W+COEF_W-1:0] product,
  output logic [ACC_W-1:0]         acc_out
);

  localparam int P_W   = DATA_W + COEF_W;
  localparam int CNT_W = $clog2(COEF_W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [P_W-1:0]    mcand;
  logic [P_W-1:0]    psum;
  logic [COEF_W-1:0] mplier;
  logic              neg;
  logic              sgn;
  logic              acc_en_r;
  logic              acc_clr_r;
  logic [P_W-1:0]    prod_q;
  logic [ACC_W-1:0]  acc_q;

  logic [DATA_W-1:0] s_mag;
  logic [COEF_W-1:0] c_mag;
  logic [P_W-1:0]    sum_nxt;
  logic [P_W-1:0]    prod_nxt;
  logic [ACC_W-1:0]  ext;
  logic [ACC_W-1:0]  acc_base;
  logic              last;

  // Magnitudes fit in the operand width even for the most negative value
  // because they are treated as unsigned from here on.
  always_comb begin
    s_mag = sample;
    c_mag = coeff;
    if (signed_mode && sample[DATA_W-1]) s_mag = -sample;
    if (signed_mode && coeff[COEF_W-1])  c_mag = -coeff;
    sum_nxt  = psum + (mplier[0] ? mcand : '0);
    prod_nxt = neg ? -sum_nxt : sum_nxt;
    ext      = sgn ? ACC_W'($signed(prod_nxt))
                   : ACC_W'(prod_nxt);
    acc_base = acc_clr_r ? '0 : acc_q;
    last     = (cnt == CNT_W'(COEF_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      psum      <= '0;
      mplier    <= '0;
      neg       <= 1'b0;
      sgn       <= 1'b0;
      acc_en_r  <= 1'b0;
      acc_clr_r <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand     <= P_W'(s_mag);
            mplier    <= c_mag;
            psum      <= '0;
            cnt       <= '0;
            neg       <= signed_mode &
                         (sample[DATA_W-1] ^ coeff[COEF_W-1]);
            sgn       <= signed_mode;
            acc_en_r  <= acc_en;
            acc_clr_r <= acc_clr;
            state     <= RUN;
          end
        end
        RUN: begin
          psum   <= sum_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            prod_q <= prod_nxt;
            if (acc_en_r)       acc_q <= acc_base + ext;
            else if (acc_clr_r) acc_q <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = prod_q;
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_seq_mac.sv
// tb_seq_mac: table vectors, random vectors against an arithmetic model,
// hold and mid-run reset sequences; 24-bit and 16-bit accumulator builds.
module tb_seq_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, signed_mode;
  logic        acc_en, acc_clr, out_ready;
  logic [7:0]  sample, coeff;
  logic        in_ready, out_valid;
  logic        in_ready_w, out_valid_w;
  logic [15:0] product, product_w;
  logic [23:0] acc_out;
  logic [15:0] acc_w;

  int vectors = 0;
  int fails   = 0;
  longint m_acc24 = 0;
  longint m_acc16 = 0;

  seq_mac #(.DATA_W(8), .COEF_W(8), .ACC_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sample(sample), .coeff(coeff),
    .signed_mode(signed_mode),
    .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .acc_out(acc_out)
  );

  seq_mac #(.DATA_W(8), .COEF_W(8), .ACC_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .sample(sample), .coeff(coeff),
    .signed_mode(signed_mode),
    .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .product(product_w), .acc_out(acc_w)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain-integer reference: product and both accumulators.
  task automatic model(input logic [7:0] s, input logic [7:0] c,
                       input logic sm, input logic ae, input logic ac,
                       output logic [15:0] p);
    longint a, b, pr;
    if (sm) begin
      a = $signed(s);
      b = $signed(c);
    end else begin
      a = s;
      b = c;
    end
    pr = a * b;
    p  = pr[15:0];
    if (ae) begin
      m_acc24 = ((ac ? 0 : m_acc24) + pr) & 64'hFFFFFF;
      m_acc16 = ((ac ? 0 : m_acc16) + pr) & 64'hFFFF;
    end else if (ac) begin
      m_acc24 = 0;
      m_acc16 = 0;
    end
  endtask

  task automatic run_txn(input logic [7:0] s, input logic [7:0] c,
                         input logic sm, input logic ae, input logic ac,
                         output int lat);
    @(negedge clk);
    sample = s; coeff = c; signed_mode = sm;
    acc_en = ae; acc_clr = ac; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    sample      = 8'($urandom);
    coeff       = 8'($urandom);
    signed_mode = 1'($urandom);
    acc_en      = 1'($urandom);
    acc_clr     = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  typedef struct {
    logic [7:0]  s;
    logic [7:0]  c;
    logic        sm;
    logic        ae;
    logic        ac;
    logic [15:0] p;
    logic [23:0] a;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int lat;
    logic [15:0] mp;
    logic [7:0] rs, rc;
    logic rsm, rae, rac;

    tbl[0]  = '{8'd3,   8'd5,   1'b0, 1'b0, 1'b0, 16'd15,    24'd0};
    tbl[1]  = '{8'd5,   8'd2,   1'b0, 1'b0, 1'b0, 16'd10,    24'd0};
    tbl[2]  = '{8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 16'hFE01,  24'd0};
    tbl[3]  = '{8'd0,   8'd200, 1'b0, 1'b0, 1'b0, 16'd0,     24'd0};
    tbl[4]  = '{8'hFD,  8'd5,   1'b1, 1'b0, 1'b0, 16'hFFF1,  24'd0};
    tbl[5]  = '{8'h80,  8'h80,  1'b1, 1'b0, 1'b0, 16'h4000,  24'd0};
    tbl[6]  = '{8'h7F,  8'h80,  1'b1, 1'b0, 1'b0, 16'hC080,  24'd0};
    tbl[7]  = '{8'd3,   8'd5,   1'b0, 1'b1, 1'b1, 16'd15,    24'd15};
    tbl[8]  = '{8'd5,   8'd2,   1'b0, 1'b1, 1'b0, 16'd10,    24'd25};
    tbl[9]  = '{8'hFD,  8'd5,   1'b1, 1'b1, 1'b0, 16'hFFF1,  24'd10};
    tbl[10] = '{8'd1,   8'd1,   1'b0, 1'b0, 1'b1, 16'd1,     24'd0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sample = '0; coeff = '0; signed_mode = 1'b0;
    acc_en = 1'b0; acc_clr = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_acc", acc_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      model(tbl[i].s, tbl[i].c, tbl[i].sm, tbl[i].ae, tbl[i].ac, mp);
      run_txn(tbl[i].s, tbl[i].c, tbl[i].sm, tbl[i].ae, tbl[i].ac, lat);
      chk($sformatf("tbl%0d_latency", i), lat, 8);
      chk($sformatf("tbl%0d_product", i), product, tbl[i].p);
      chk($sformatf("tbl%0d_product_w", i), product_w, tbl[i].p);
      chk($sformatf("tbl%0d_acc", i), acc_out, tbl[i].a);
      chk($sformatf("tbl%0d_acc_w", i), acc_w, {8'd0, tbl[i].a[15:0]});
      release_out();
    end

    for (int i = 0; i < 16; i++) begin
      model(8'd255, 8'd255, 1'b0, 1'b1, i == 0, mp);
      run_txn(8'd255, 8'd255, 1'b0, 1'b1, i == 0, lat);
      release_out();
    end
    chk("wrap_acc_w", acc_w, 57360);
    chk("wrap_acc24", acc_out, 1040400);

    for (int i = 0; i < 40; i++) begin
      rs  = 8'($urandom);
      rc  = 8'($urandom);
      rsm = 1'($urandom);
      rae = 1'($urandom);
      rac = ($urandom_range(0, 3) == 0);
      model(rs, rc, rsm, rae, rac, mp);
      run_txn(rs, rc, rsm, rae, rac, lat);
      chk($sformatf("rnd%0d_latency", i), lat, 8);
      chk($sformatf("rnd%0d_product", i), product, mp);
      chk($sformatf("rnd%0d_acc", i), acc_out, m_acc24);
      chk($sformatf("rnd%0d_acc_w", i), acc_w, m_acc16);
      release_out();
    end

    model(8'd7, 8'd9, 1'b0, 1'b1, 1'b0, mp);
    run_txn(8'd7, 8'd9, 1'b0, 1'b1, 1'b0, lat);
    chk("hold_latency", lat, 8);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      sample = 8'd100 + 8'(k);
      coeff = 8'd3;
      acc_en = 1'b1;
      acc_clr = 1'b1;
      @(negedge clk);
      chk($sformatf("hold%0d_out_valid", k), out_valid, 1);
      chk($sformatf("hold%0d_in_ready", k), in_ready, 0);
      chk($sformatf("hold%0d_product", k), product, mp);
      chk($sformatf("hold%0d_acc", k), acc_out, m_acc24);
    end
    in_valid = 1'b0;
    release_out();

    model(8'd3, 8'd5, 1'b0, 1'b1, 1'b1, mp);
    run_txn(8'd3, 8'd5, 1'b0, 1'b1, 1'b1, lat);
    chk("pre_rst_acc", acc_out, 15);
    release_out();
    @(negedge clk);
    sample = 8'd3; coeff = 8'd5; signed_mode = 1'b0;
    acc_en = 1'b1; acc_clr = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("run_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_in_ready_w", in_ready_w, 1);
    chk("midrst_acc", acc_out, 0);
    chk("midrst_acc_w", acc_w, 0);
    m_acc24 = 0;
    m_acc16 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    model(8'd3, 8'd5, 1'b0, 1'b0, 1'b0, mp);
    run_txn(8'd3, 8'd5, 1'b0, 1'b0, 1'b0, lat);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_product", product, 15);
    chk("post_rst_valid_w", out_valid_w, 1);
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
